// File: rtl/voice_pkg.sv
// Shared constants and types for the voice frame sequencer.
//   DEF_*       : default generics (sample period, strobe phase, frame length,
//                 sample-buffer address width)
//   FRAME_CNT_W : width of the completed-frame counter
//   IDX_W       : width of the in-frame sample index
//   state_e     : sequencer FSM states
package voice_pkg;

  localparam int unsigned DEF_DIV       = 512;
  localparam int unsigned DEF_PHASE     = 10;
  localparam int unsigned DEF_FRAME_LEN = 768;
  localparam int unsigned DEF_ADDR_W    = 11;
  localparam int unsigned FRAME_CNT_W   = 16;
  localparam int unsigned IDX_W         = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/sample_rate_divider.sv
// Sample-period divider with a registered one-cycle strobe.
//   clk      : clock
//   run      : count while high; counter held at 0 and strobe cleared when low
//   sync_clr : synchronous clear of counter and strobe (dominates run)
//   strobe   : one-cycle pulse, set on the edge where the counter equals PHASE
module sample_rate_divider
  import voice_pkg::*;
#(
  parameter int unsigned DIV   = DEF_DIV,
  parameter int unsigned PHASE = DEF_PHASE
) (
  input  logic clk,
  input  logic run,
  input  logic sync_clr,
  output logic strobe
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (sync_clr) begin
      div_cnt <= '0;
      strobe  <= 1'b0;
    end else if (run) begin
      div_cnt <= (div_cnt == CW'(DIV - 1)) ? '0 : div_cnt + CW'(1);
      // DIV >= PHASE+2 guarantees the strobe falls on the very next edge.
      strobe  <= (div_cnt == CW'(PHASE));
    end else begin
      div_cnt <= '0;
      strobe  <= 1'b0;
    end
  end

endmodule

// File: rtl/voice_frame_sequencer.sv
// Sample-rate and frame sequencer feeding change_voice.
//   clk, reset   : clock, synchronous active-high reset
//   enable       : run request
//   mode_req     : requested RisingTone mode, taken only at frame boundaries
//   ready        : one-cycle sample strobe
//   rising_tone  : mode applied to change_voice.RisingTone
//   rd_addr      : sample-buffer address of the sample presented with ready
//   sample_idx   : position within the current frame
//   frame_start  : ready of the first sample in a frame
//   frame_cnt    : completed frames (wraps)
//   busy         : sequencer not idle
module voice_frame_sequencer
  import voice_pkg::*;
#(
  parameter int unsigned DIV       = DEF_DIV,
  parameter int unsigned PHASE     = DEF_PHASE,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   mode_req,
  output logic                   ready,
  output logic                   rising_tone,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic [IDX_W-1:0]       sample_idx,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy
);

  state_e state, state_next;
  logic   start;
  logic   frame_wrap;

  assign start      = (state == IDLE) && enable;
  // The edge that ends the last strobe of a frame.
  assign frame_wrap = ready && (sample_idx == IDX_W'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable) state_next = RUN;
      RUN:  if (!enable) state_next = STOP;
      // Re-enable wins over completion so strobes continue uninterrupted.
      STOP: begin
        if (enable)          state_next = RUN;
        else if (frame_wrap) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  sample_rate_divider #(
    .DIV   (DIV),
    .PHASE (PHASE)
  ) u_div (
    .clk      (clk),
    .run      (state != IDLE),
    .sync_clr (reset || start),
    .strobe   (ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr     <= '0;
      sample_idx  <= '0;
      frame_cnt   <= '0;
      rising_tone <= 1'b0;
    end else begin
      if (start) rising_tone <= mode_req;
      if (ready) begin
        rd_addr <= rd_addr + ADDR_W'(1);
        if (frame_wrap) begin
          sample_idx  <= '0;
          frame_cnt   <= frame_cnt + FRAME_CNT_W'(1);
          rising_tone <= mode_req;
        end else begin
          sample_idx <= sample_idx + IDX_W'(1);
        end
      end
    end
  end

  assign frame_start = ready && (sample_idx == '0);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_voice_frame_sequencer.sv
module tb_voice_frame_sequencer;
  import voice_pkg::*;

  localparam int T_DIV   = 16;
  localparam int T_PHASE = 10;
  localparam int T_FRAME = 12;
  localparam int T_AW    = 5;
  localparam int T_DEPTH = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic                   mode_req;
  logic                   ready;
  logic                   rising_tone;
  logic [T_AW-1:0]        rd_addr;
  logic [IDX_W-1:0]       sample_idx;
  logic                   frame_start;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   busy;

  always #5 clk = ~clk;

  voice_frame_sequencer #(
    .DIV       (T_DIV),
    .PHASE     (T_PHASE),
    .FRAME_LEN (T_FRAME),
    .ADDR_W    (T_AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode_req    (mode_req),
    .ready       (ready),
    .rising_tone (rising_tone),
    .rd_addr     (rd_addr),
    .sample_idx  (sample_idx),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int cyc;
    int addr;
    int idx;
    int fs;
    int tone;
    int fcnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic prev_ready = 1'b0;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(int at, int addr, int idx, int fcnt, int tone);
    exp_t e;
    e.cyc  = at;
    e.addr = addr;
    e.idx  = idx;
    e.fs   = (idx == 0) ? 1 : 0;
    e.tone = tone;
    e.fcnt = fcnt;
    q.push_back(e);
  endfunction

  task automatic wait_cyc(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every observed strobe is matched against the next expected one.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      check("ready_width", int'(prev_ready), 0);
      if (q.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("strobe_cycle", cyc, mon_e.cyc);
        check("rd_addr", int'(rd_addr), mon_e.addr);
        check("sample_idx", int'(sample_idx), mon_e.idx);
        check("frame_start", int'(frame_start), mon_e.fs);
        check("rising_tone", int'(rising_tone), mon_e.tone);
        check("frame_cnt", int'(frame_cnt), mon_e.fcnt);
      end
    end
    prev_ready <= (ready === 1'b1);
  end

  int e0, e1, e2;

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    mode_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", int'(ready), 0);
    check("rst_rising_tone", int'(rising_tone), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_sample_idx", int'(sample_idx), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_busy", int'(busy), 0);

    // Run 4 frames; mode 1 requested in frame 0, withdrawn in frame 1,
    // enable dropped at sample 4 of frame 3 so that frame still completes.
    enable = 1'b1;
    e0 = cyc + 1;
    for (int n = 0; n < 48; n++)
      push(e0 + T_PHASE + 1 + T_DIV * n, n % T_DEPTH, n % T_FRAME,
           n / T_FRAME, (n / T_FRAME == 1) ? 1 : 0);
    @(negedge clk);
    check("busy_after_e0", int'(busy), 1);
    wait_cyc(e0 + 11 + T_DIV * 3 + 2);
    mode_req = 1'b1;
    wait_cyc(e0 + 11 + T_DIV * 20 + 2);
    mode_req = 1'b0;
    wait_cyc(e0 + 11 + T_DIV * 40 + 2);
    enable = 1'b0;
    wait_cyc(e0 + 11 + T_DIV * 47);
    check("busy_last_strobe", int'(busy), 1);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_frame_cnt", int'(frame_cnt), 4);
    check("idle_sample_idx", int'(sample_idx), 0);
    check("idle_rd_addr", int'(rd_addr), 16);
    wait_cyc(cyc + 3 * T_DIV);
    check("queue_drained_b", q.size(), 0);
    check("idle_busy_later", int'(busy), 0);

    // Restart from IDLE with mode 1: tone loads on start; stop/restart mid-frame.
    mode_req = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    e1 = cyc + 1;
    for (int m = 0; m < 18; m++)
      push(e1 + T_PHASE + 1 + T_DIV * m, (16 + m) % T_DEPTH, m % T_FRAME,
           4 + m / T_FRAME, 1);
    @(negedge clk);
    check("start_tone_load", int'(rising_tone), 1);
    wait_cyc(e1 + 11 + T_DIV * 4 + 2);
    enable = 1'b0;
    wait_cyc(e1 + 11 + T_DIV * 6);
    check("stop_busy", int'(busy), 1);
    wait_cyc(e1 + 11 + T_DIV * 8 + 2);
    enable = 1'b1;

    // Reset asserted while a strobe is high, enable still requested.
    wait_cyc(e1 + 11 + T_DIV * 17);
    check("ready_at_reset", int'(ready), 1);
    reset = 1'b1;
    @(negedge clk);
    check("pr_ready", int'(ready), 0);
    check("pr_rising_tone", int'(rising_tone), 0);
    check("pr_rd_addr", int'(rd_addr), 0);
    check("pr_sample_idx", int'(sample_idx), 0);
    check("pr_frame_start", int'(frame_start), 0);
    check("pr_frame_cnt", int'(frame_cnt), 0);
    check("pr_busy", int'(busy), 0);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("post_reset_idle", int'(busy), 0);
    check("queue_drained_c", q.size(), 0);

    mode_req = 1'b0;
    enable   = 1'b1;
    e2 = cyc + 1;
    for (int k = 0; k < 3; k++)
      push(e2 + T_PHASE + 1 + T_DIV * k, k, k, 0, 0);
    wait_cyc(e2 + 11 + T_DIV * 2 + 4);
    check("queue_drained_d", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
